// File: rtl/dmem_dump_reader.sv
// Streams a contiguous range of data-memory words out over valid/ready.
// Per word: one read strobe, one capture cycle, then a hold until the consumer accepts.
module dmem_dump_reader #(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dump_req,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [31:0]       mem_rd_data,
   output logic              out_valid,
   output logic [31:0]       out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_HOLD,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] cur;
   logic [ADDR_W:0]   rem;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         cur         <= '0;
         rem         <= '0;
         mem_rd_addr <= '0;
         out_data    <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (dump_req) begin
                  cur <= base_addr;
                  rem <= word_count;
                  // Read address only moves when a read is actually coming.
                  if (word_count != '0) mem_rd_addr <= base_addr;
               end
            end
            S_WAIT: begin
               out_data <= mem_rd_data;
               cur      <= cur + ADDR_W'(1);
               rem      <= rem - (ADDR_W+1)'(1);
            end
            S_HOLD: begin
               if (out_ready && rem != '0) mem_rd_addr <= cur;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx  = state;
      mem_rd_en = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (dump_req) state_nx = (word_count != '0) ? S_READ : S_DONE;
         end
         S_READ: begin
            mem_rd_en = 1'b1;
            state_nx  = S_WAIT;
         end
         S_WAIT: state_nx = S_HOLD;
         S_HOLD: begin
            out_valid = 1'b1;
            out_last  = (rem == '0);
            if (out_ready) state_nx = (rem == '0) ? S_DONE : S_READ;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader with a 1-cycle-latency memory model.
module tb_dmem_dump_reader;

   logic        clock = 1'b0;
   logic        reset;
   logic        dump_req;
   logic [7:0]  base_addr;
   logic [8:0]  word_count;
   logic        mem_rd_en;
   logic [7:0]  mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_ready;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [256];
   logic [7:0]  rd_log[$];
   logic [31:0] got[$];
   logic        lastq[$];
   int          first_valid, done_cyc, last_hs;
   logic        stall_bad;

   always #5 clock = ~clock;

   dmem_dump_reader #(.ADDR_W(8)) dut (
      .clock(clock), .reset(reset), .dump_req(dump_req), .base_addr(base_addr),
      .word_count(word_count), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done)
   );

   always @(posedge clock) begin
      if (mem_rd_en) begin
         mem_rd_data <= mem[mem_rd_addr];
         rd_log.push_back(mem_rd_addr);
      end
   end

   function automatic logic [31:0] mval(input logic [7:0] a);
      logic [31:0] x;
      x = {24'd0, a};
      return x * 32'h11111111;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one dump; stall = number of cycles out_ready is held low per word.
   task automatic run_dump(input logic [7:0] b, input logic [8:0] n, input int stall);
      int cyc;
      int wait_cnt;
      logic [31:0] held_d;
      logic        held_l;
      rd_log.delete();
      got.delete();
      lastq.delete();
      first_valid = -1;
      done_cyc    = -1;
      last_hs     = -1;
      stall_bad   = 1'b0;
      wait_cnt    = 0;
      held_d      = '0;
      held_l      = 1'b0;
      base_addr   = b;
      word_count  = n;
      dump_req    = 1'b1;
      out_ready   = (stall == 0);
      tick();
      dump_req = 1'b0;
      cyc      = 1;
      while (cyc < 2000 && done_cyc < 0) begin
         if (done) done_cyc = cyc;
         if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (wait_cnt == 0) begin
               held_d = out_data;
               held_l = out_last;
            end else if (out_data !== held_d || out_last !== held_l) begin
               stall_bad = 1'b1;
            end
            if (wait_cnt < stall) begin
               out_ready = 1'b0;
               wait_cnt++;
            end else begin
               out_ready = 1'b1;
               got.push_back(out_data);
               lastq.push_back(out_last);
               last_hs  = cyc;
               wait_cnt = 0;
            end
         end else begin
            out_ready = (stall == 0);
         end
         tick();
         cyc++;
      end
      chk("dump_timeout", done_cyc >= 0, 1);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      out_ready = 1'b0;
   endtask

   task automatic check_words(input string tag, input logic [7:0] b, input int n);
      int bad_d = 0;
      int bad_a = 0;
      int bad_l = 0;
      logic [7:0] a;
      chk({tag, "_count"}, got.size(), n);
      chk({tag, "_reads"}, rd_log.size(), n);
      for (int i = 0; i < n && i < got.size() && i < rd_log.size(); i++) begin
         a = b + 8'(i);
         if (got[i] !== mval(a)) bad_d++;
         if (rd_log[i] !== a) bad_a++;
         if (lastq[i] !== (i == n - 1)) bad_l++;
      end
      chk({tag, "_data_bad"}, bad_d, 0);
      chk({tag, "_addr_bad"}, bad_a, 0);
      chk({tag, "_last_bad"}, bad_l, 0);
   endtask

   initial begin
      logic saw_rd;
      logic saw_done;
      for (int i = 0; i < 256; i++) mem[i] = mval(8'(i));
      reset      = 1'b1;
      dump_req   = 1'b0;
      base_addr  = '0;
      word_count = '0;
      out_ready  = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // 1: idle after reset
      saw_rd = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (mem_rd_en || out_valid || out_last || busy || done) saw_rd = 1'b1;
         tick();
      end
      chk("rst_outputs_quiet", saw_rd, 0);
      chk("rst_rd_addr", mem_rd_addr, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_no_reads", rd_log.size(), 0);

      // 2: base 2, count 3, always ready
      run_dump(8'd2, 9'd3, 0);
      check_words("t2", 8'd2, 3);
      chk("t2_word0", got.size() > 0 ? got[0] : 32'hx, 32'h22222222);
      chk("t2_word2", got.size() > 2 ? got[2] : 32'hx, 32'h44444444);
      chk("t2_first_valid", first_valid, 3);
      chk("t2_done_after_last", done_cyc, last_hs + 1);
      chk("t2_done_cycle", done_cyc, 10);

      // 3: same dump, 4 stall cycles per word
      run_dump(8'd2, 9'd3, 4);
      check_words("t3", 8'd2, 3);
      chk("t3_stable", stall_bad, 0);
      chk("t3_done_after_last", done_cyc, last_hs + 1);

      // 4: address wrap
      run_dump(8'hFE, 9'd3, 0);
      check_words("t4", 8'hFE, 3);
      chk("t4_third_addr", rd_log.size() > 2 ? rd_log[2] : 8'hx, 8'h00);

      // 5: empty dump goes straight to DONE, then full-memory dump
      run_dump(8'h30, 9'd0, 0);
      chk("t5_zero_done_cycle", done_cyc, 1);
      chk("t5_zero_no_reads", rd_log.size(), 0);
      chk("t5_zero_no_words", got.size(), 0);
      run_dump(8'h00, 9'd256, 0);
      check_words("t5_full", 8'h00, 256);

      // 6: reset while word 2 of 5 is held
      base_addr  = 8'h40;
      word_count = 9'd5;
      out_ready  = 1'b1;
      dump_req   = 1'b1;
      tick();
      dump_req = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) tick();
      chk("t6_word1_valid", out_valid, 1);
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) tick();
      chk("t6_word2_valid", out_valid, 1);
      chk("t6_word2_data", out_data, mval(8'h41));
      reset = 1'b1;
      tick();
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_busy", busy, 0);
      reset    = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (done || busy || out_valid) saw_done = 1'b1;
         tick();
      end
      chk("t6_no_done", saw_done, 0);
      run_dump(8'h80, 9'd2, 0);
      check_words("t6_restart", 8'h80, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
